// File: rtl/uart_tx_fifo.sv
//==============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO plus issue sequencer feeding uart_tx via DV/Active/Done.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Wr_DV,
  input  logic [7:0]        i_Wr_Byte,
  input  logic              i_Ovf_Clr,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_Busy,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done
);

  localparam logic [ADDR_W:0]   c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_PTR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACT  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                tx_dv_q;
  logic [7:0]          tx_byte_q;

  logic w_full, w_empty, w_wr_ok, w_pop;

  assign w_full  = (count_q == c_DEPTH_CNT);
  assign w_empty = (count_q == '0);
  assign w_wr_ok = i_Wr_DV && !w_full;
  // Done guard holds off issue through uart_tx's stop/cleanup cycles and after a mid-frame reset.
  assign w_pop   = (state_q == S_IDLE) && !w_empty && !i_Tx_Active && !i_Tx_Done;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (w_wr_ok) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    if (w_pop)   rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    case ({w_wr_ok, w_pop})
      2'b10:   count_d = count_q + c_CNT_ONE;
      2'b01:   count_d = count_q - c_CNT_ONE;
      default: count_d = count_q;
    endcase
    if (i_Wr_DV && w_full) ovf_d = 1'b1;
    else if (i_Ovf_Clr)    ovf_d = 1'b0;
  end

  always_ff @(posedge i_Clock) begin
    if (w_wr_ok) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      case (state_q)
        S_IDLE: begin
          if (w_pop) begin
            tx_byte_q <= mem_q[rd_ptr_q];
            tx_dv_q   <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tx_dv_q <= 1'b0;
          state_q <= S_WAIT_ACT;
        end
        S_WAIT_ACT: begin
          if (i_Tx_Active) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_Tx_Done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Full     = w_full;
  assign o_Empty    = w_empty;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_Busy     = (state_q != S_IDLE);
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
//==============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo with a behavioural uart_tx.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CPB    = 4;

  logic clk = 1'b0, rst_n = 1'b0, wr_dv = 1'b0, ovf_clr = 1'b0, blk = 1'b1;
  logic [7:0] wr_byte = 8'h00;
  logic full, empty, ovf, busy, tx_dv;
  logic [ADDR_W:0] count;
  logic [7:0] tx_byte;

  // uart_tx model state: 0 idle, 1 start, 2 data, 3 stop, 4 cleanup; no reset
  logic m_active = 1'b0, m_done = 1'b0, m_line = 1'b1;
  int   m_st = 0, m_cnt = 0, m_idx = 0;
  logic [7:0] m_sh = 8'h00;

  int total = 0, bad = 0, max_cnt = 0, viol = 0;
  logic chk6_en = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte),
    .i_Ovf_Clr(ovf_clr), .o_Full(full), .o_Empty(empty), .o_Count(count),
    .o_Overflow(ovf), .o_Busy(busy), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(m_active | blk), .i_Tx_Done(m_done)
  );

  always @(posedge clk) begin
    case (m_st)
      0: begin
        m_line <= 1'b1; m_done <= 1'b0; m_cnt <= 0; m_idx <= 0;
        if (tx_dv) begin m_active <= 1'b1; m_sh <= tx_byte; m_st <= 1; end
      end
      1: begin
        m_line <= 1'b0;
        if (m_cnt < CPB-1) m_cnt <= m_cnt + 1; else begin m_cnt <= 0; m_st <= 2; end
      end
      2: begin
        m_line <= m_sh[m_idx];
        if (m_cnt < CPB-1) m_cnt <= m_cnt + 1;
        else begin
          m_cnt <= 0;
          if (m_idx < 7) m_idx <= m_idx + 1; else begin m_idx <= 0; m_st <= 3; end
        end
      end
      3: begin
        m_line <= 1'b1;
        if (m_cnt < CPB-1) m_cnt <= m_cnt + 1;
        else begin m_cnt <= 0; m_done <= 1'b1; m_active <= 1'b0; m_st <= 4; end
      end
      default: begin m_done <= 1'b1; m_st <= 0; end
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Serial line receiver: samples mid-bit and scores each byte against exp_q.
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk);
      if (m_line == 1'b0) begin
        repeat (CPB/2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          b[i] = m_line;
        end
        repeat (CPB) @(posedge clk);
        chk("stop_bit", int'(m_line), 1);
        if (exp_q.size() > 0) chk("rx_byte", int'(b), int'(exp_q.pop_front()));
        else chk("rx_extra_byte", int'(b), 256);
      end
    end
  end

  always @(negedge clk) begin
    if (int'(count) > max_cnt) max_cnt = int'(count);
    if (chk6_en && tx_dv && (m_active || m_done)) viol++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string nm, input int bound);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy && empty && m_st == 0 && !m_done) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(n < bound), 1);
  endtask

  task automatic write_burst(input logic [7:0] first, input int n, input logic push);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_dv = 1'b1;
      wr_byte = 8'(first + 8'(i));
      if (push) exp_q.push_back(wr_byte);
    end
    @(negedge clk);
    wr_dv = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    int         cnt;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int n;
    tbl[0] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 16; i++)
      tbl[1+i] = '{1'b1, 8'(8'h40 + 8'(i)), 1'b0, i+1, (i == 15), 1'b0, 1'b0};
    tbl[17] = '{1'b1, 8'h99, 1'b0, 16, 1'b1, 1'b0, 1'b1};  // drop while full
    tbl[18] = '{1'b1, 8'h9A, 1'b1, 16, 1'b1, 1'b0, 1'b1};  // drop beats clear
    tbl[19] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 16, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_txdv", int'(tx_dv), 0);
    chk("rst_txbyte", int'(tx_byte), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk) rst_n = 1'b1;

    // Table vectors with the sequencer held off
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      wr_dv = tbl[k].wr; wr_byte = tbl[k].d; ovf_clr = tbl[k].clr;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", k), int'(count), tbl[k].cnt);
      chk($sformatf("vec%0d_full", k), int'(full), int'(tbl[k].full));
      chk($sformatf("vec%0d_empty", k), int'(empty), int'(tbl[k].empty));
      chk($sformatf("vec%0d_ovf", k), int'(ovf), int'(tbl[k].ovf));
    end
    @(negedge clk);
    wr_dv = 1'b0; ovf_clr = 1'b0; blk = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h40 + 8'(i)));
    wait_idle("drain_table", 2000);

    // Asynchronous reset mid-run with full FIFO and overflow set
    blk = 1'b1;
    write_burst(8'h10, 17, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_ovf", int'(ovf), 1);
    chk("pre_rst_txbyte", int'(tx_byte), 8'h4F);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_empty", int'(empty), 1);
    chk("async_rst_full", int'(full), 0);
    chk("async_rst_ovf", int'(ovf), 0);
    chk("async_rst_txbyte", int'(tx_byte), 0);
    chk("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1; blk = 1'b0;

    // Single byte: no bypass, one-cycle DV one edge after the write
    @(negedge clk); wr_dv = 1'b1; wr_byte = 8'hA5; exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    chk("single_dv_n", int'(tx_dv), 0);
    chk("single_cnt_n", int'(count), 1);
    @(negedge clk) wr_dv = 1'b0;
    @(posedge clk); #1;
    chk("single_dv_n1", int'(tx_dv), 1);
    chk("single_byte", int'(tx_byte), 8'hA5);
    chk("single_busy", int'(busy), 1);
    chk("single_cnt_n1", int'(count), 0);
    @(posedge clk); #1;
    chk("single_dv_n2", int'(tx_dv), 0);
    wait_idle("single_idle", 200);

    // Simultaneous write and pop at count=1
    @(negedge clk); wr_dv = 1'b1; wr_byte = 8'hC1; exp_q.push_back(8'hC1);
    @(negedge clk); wr_byte = 8'hC2; exp_q.push_back(8'hC2);
    @(posedge clk); #1;
    chk("simul_count", int'(count), 1);
    chk("simul_empty", int'(empty), 0);
    chk("simul_byte", int'(tx_byte), 8'hC1);
    @(negedge clk) wr_dv = 1'b0;
    wait_idle("simul_idle", 400);

    // Burst of 18: 0x00 issued at once, 16 queued, 0x11 dropped
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      wr_dv = 1'b1; wr_byte = 8'(i);
      if (i < 17) exp_q.push_back(8'(i));
      @(posedge clk); #1;
      if (i == 16) begin
        chk("burst_full", int'(full), 1);
        chk("burst_count", int'(count), 16);
        chk("burst_ovf_pre", int'(ovf), 0);
      end
    end
    chk("burst_ovf", int'(ovf), 1);
    chk("burst_count_drop", int'(count), 16);
    @(negedge clk) wr_dv = 1'b0;
    wait_idle("burst_idle", 2000);
    chk("burst_ovf_sticky", int'(ovf), 1);
    @(negedge clk) ovf_clr = 1'b1;
    @(posedge clk); #1;
    chk("burst_ovf_clr", int'(ovf), 0);
    @(negedge clk) ovf_clr = 1'b0;

    // Wrap: 8 groups of 5
    for (int g = 0; g < 8; g++) begin
      write_burst(8'(8'h80 + 8'(g*5)), 5, 1'b1);
      wait_idle($sformatf("wrap_idle_g%0d", g), 600);
    end

    // Reset during S_WAIT_DONE with 3 bytes queued
    write_burst(8'h71, 4, 1'b0);
    exp_q.push_back(8'h71);
    n = 0;
    while (m_st != 2 && n < 100) begin @(negedge clk); n++; end
    chk("r6_reach_data", int'(n < 100), 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("r6_count", int'(count), 0);
    chk("r6_busy", int'(busy), 0);
    exp_q.push_back(8'h3C);
    @(negedge clk);
    rst_n = 1'b1; chk6_en = 1'b1; wr_dv = 1'b1; wr_byte = 8'h3C;
    @(negedge clk) wr_dv = 1'b0;
    n = 0;
    while (!tx_dv && n < 300) begin @(negedge clk); n++; end
    chk("r6_issue_seen", int'(n < 300), 1);
    chk("r6_issue_byte", int'(tx_byte), 8'h3C);
    chk("r6_issue_active", int'(m_active), 0);
    chk("r6_issue_done", int'(m_done), 0);
    wait_idle("r6_idle", 400);
    chk6_en = 1'b0;
    chk("r6_dv_while_busy", viol, 0);
    repeat (60) @(negedge clk);
    chk("r6_no_extra", exp_q.size(), 0);

    chk("max_count", max_cnt, 16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
